// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write engine.
//  - lcd_state_e : engine FSM states
//  - CMD_*       : bit positions inside the 32-bit LSU command word
//  - INIT_ROM    : power-up init bytes, sent in index order 0..3 with RS=0
//  - is_slow_cmd : clear/home commands need the long execute wait
//  - max_int     : helper for sizing the shared timer
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC,
    ST_IDLE
  } lcd_state_e;

  localparam int CMD_ON_BIT   = 31;
  localparam int CMD_RS_BIT   = 9;
  localparam int CMD_DATA_MSB = 7;
  localparam int CMD_DATA_LSB = 0;

  localparam int INIT_LEN = 4;
  // Element 0 is the first byte sent: function set, display on, clear, entry mode.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

  // Clear (0x01) and return-home (0x02/0x03) are the only instructions with
  // the multi-millisecond execute time; data writes are never slow.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_write_engine_timer.sv
// Down-counter shared by every timed state of the LCD write engine.
//  clk_i, rst_i : clock, synchronous active-high reset (counter <- RST_VAL)
//  load_i       : load load_val_i this cycle (takes priority over counting)
//  value_o      : current count
//  zero_o       : count has reached 0; the counter holds there, never wraps
module lcd_timer #(
  parameter int W       = 8,
  parameter int RST_VAL = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= W'(RST_VAL);
    end else begin
      count_q <= count_d;
    end
  end

  assign value_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780-style LCD write engine fed by LSU stores to the LCD register.
// Runs the power-up init sequence itself, then accepts one command word at a
// time and sequences setup / EN pulse / hold / execute wait on the LCD pins.
//  clk_i, rst_i   : clock, synchronous active-high reset
//  cmd_valid_i    : LSU store to the LCD address
//  cmd_data_i     : [31]=LCD_ON, [9]=RS, [7:0]=byte
//  cmd_ready_o    : command accepted when high together with cmd_valid_i
//  status_o       : {30'b0, init_done, busy}
//  lcd_on_o       : LCD power/backlight enable
//  lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o : LCD pins (rw is always 0)
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int T_PWRUP_CYC = 375000,
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 1000,
  parameter int T_CLEAR_CYC = 41000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_data_i,
  output logic        cmd_ready_o,
  output logic [31:0] status_o,
  output logic        lcd_on_o,
  output logic        lcd_en_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic [7:0]  lcd_data_o
);

  localparam int T_MAX = max_int(max_int(max_int(T_PWRUP_CYC, T_SETUP_CYC), max_int(T_EN_CYC, T_HOLD_CYC)),
                                 max_int(T_EXEC_CYC, T_CLEAR_CYC));
  localparam int TW = $clog2(T_MAX + 1);

  lcd_state_e  state_q, state_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic        init_done_q, init_done_d;
  logic        ready_q, ready_d;
  logic        on_q, on_d;
  logic        en_q, en_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;

  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic [TW-1:0] timer_value_unused;
  logic          timer_zero;
  logic          accept;
  logic          unused_cmd_bits;

  lcd_timer #(
    .W       (TW),
    .RST_VAL (T_PWRUP_CYC)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .value_o    (timer_value_unused),
    .zero_o     (timer_zero)
  );

  assign accept          = cmd_valid_i && ready_q;
  assign unused_cmd_bits = ^{cmd_data_i[30:10], cmd_data_i[8]};

  // Every state transition reloads the timer with (duration - 1), so a state
  // lasts exactly its cycle count and advances on the cycle the timer hits 0.
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    ready_d     = 1'b0;
    on_d        = on_q;
    en_d        = 1'b0;
    rs_d        = rs_q;
    data_d      = data_q;
    timer_load  = 1'b0;
    timer_val   = '0;
    case (state_q)
      ST_PWRUP: begin
        on_d = 1'b1;
        if (timer_zero) begin
          state_d    = ST_LOAD;
          timer_load = 1'b1;
          rs_d       = 1'b0;
          data_d     = INIT_ROM[init_idx_q];
        end
      end
      ST_LOAD: begin
        if (timer_zero) begin
          state_d    = ST_SETUP;
          timer_load = 1'b1;
          timer_val  = TW'(T_SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (timer_zero) begin
          state_d    = ST_PULSE;
          en_d       = 1'b1;
          timer_load = 1'b1;
          timer_val  = TW'(T_EN_CYC - 1);
        end
      end
      ST_PULSE: begin
        en_d = 1'b1;
        if (timer_zero) begin
          state_d    = ST_HOLD;
          en_d       = 1'b0;
          timer_load = 1'b1;
          timer_val  = TW'(T_HOLD_CYC - 1);
        end
      end
      ST_HOLD: begin
        if (timer_zero) begin
          state_d    = ST_EXEC;
          timer_load = 1'b1;
          timer_val  = is_slow_cmd(rs_q, data_q) ? TW'(T_CLEAR_CYC - 1) : TW'(T_EXEC_CYC - 1);
        end
      end
      ST_EXEC: begin
        if (timer_zero) begin
          if (!init_done_q && (init_idx_q != 2'(INIT_LEN - 1))) begin
            state_d    = ST_LOAD;
            init_idx_d = init_idx_q + 2'd1;
            timer_load = 1'b1;
            rs_d       = 1'b0;
            data_d     = INIT_ROM[init_idx_q + 2'd1];
          end else begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
            ready_d     = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (accept) begin
          // Bus and power enable latch on the accept edge; ready drops after it.
          state_d    = ST_SETUP;
          on_d       = cmd_data_i[CMD_ON_BIT];
          rs_d       = cmd_data_i[CMD_RS_BIT];
          data_d     = cmd_data_i[CMD_DATA_MSB:CMD_DATA_LSB];
          timer_load = 1'b1;
          timer_val  = TW'(T_SETUP_CYC - 1);
        end else begin
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_PWRUP;
        init_idx_d = '0;
        timer_load = 1'b1;
        timer_val  = TW'(T_PWRUP_CYC);
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_PWRUP;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      on_q        <= 1'b0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      on_q        <= on_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign status_o    = {30'b0, init_done_q, ~ready_q};
  assign lcd_on_o    = on_q;
  assign lcd_en_o    = en_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_data_o  = data_q;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine with shortened timing:
// PWRUP=20, SETUP=2, EN=4, HOLD=2, EXEC=10, CLEAR=30, 40 ns clock.
module tb_lcd_write_engine;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic [31:0] cmd_data_i = 32'h0;
  logic        cmd_ready_o;
  logic [31:0] status_o;
  logic        lcd_on_o;
  logic        lcd_en_o;
  logic        lcd_rs_o;
  logic        lcd_rw_o;
  logic [7:0]  lcd_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #20 clk = ~clk;

  lcd_write_engine #(
    .T_PWRUP_CYC (20),
    .T_SETUP_CYC (2),
    .T_EN_CYC    (4),
    .T_HOLD_CYC  (2),
    .T_EXEC_CYC  (10),
    .T_CLEAR_CYC (30)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_data_i  (cmd_data_i),
    .cmd_ready_o (cmd_ready_o),
    .status_o    (status_o),
    .lcd_on_o    (lcd_on_o),
    .lcd_en_o    (lcd_en_o),
    .lcd_rs_o    (lcd_rs_o),
    .lcd_rw_o    (lcd_rw_o),
    .lcd_data_o  (lcd_data_o)
  );

  // Advance one clock and sample 1 ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts low samples until EN is seen high; ok=0 if the budget runs out.
  task automatic wait_en_rise(input int budget, output int lows, output bit ok);
    lows = 0;
    ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (lcd_en_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      lows++;
      tick();
    end
  endtask

  // Called on the first EN-high sample; returns on the first EN-low sample.
  task automatic measure_pulse(output int width, output logic [7:0] d, output logic rs);
    width = 0;
    d     = lcd_data_o;
    rs    = lcd_rs_o;
    while (lcd_en_o === 1'b1 && width < 100) begin
      width++;
      tick();
    end
  endtask

  task automatic send_cmd(input logic [31:0] w);
    cmd_valid_i = 1'b1;
    cmd_data_i  = w;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  // Four init pulses: 38,0C,01,06, RS=0, 4 cycles wide. EN-low gaps between
  // pulses are HOLD+EXEC+LOAD+SETUP = 15, or 35 after the clear byte.
  task automatic run_init_check(input string tag);
    logic [7:0] exp_b [4];
    int         exp_gap [4];
    int         lows, width, c;
    bit         ok;
    logic [7:0] d;
    logic       rs;
    exp_b[0] = 8'h38; exp_b[1] = 8'h0C; exp_b[2] = 8'h01; exp_b[3] = 8'h06;
    exp_gap[0] = 0; exp_gap[1] = 15; exp_gap[2] = 15; exp_gap[3] = 35;
    for (int i = 0; i < 4; i++) begin
      wait_en_rise(200, lows, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s init_rise[%0d]: EN high=%0b, required 1 within budget", tag, i, ok);
        return;
      end
      if (i > 0) begin
        n_checks++;
        if (lows !== exp_gap[i]) begin
          n_fail++;
          $display("FAIL %s init_gap[%0d]: got %0d cycles, required %0d", tag, i, lows, exp_gap[i]);
        end
      end
      measure_pulse(width, d, rs);
      n_checks++;
      if (width !== 4) begin
        n_fail++;
        $display("FAIL %s init_width[%0d]: got %0d, required 4", tag, i, width);
      end
      n_checks++;
      if (d !== exp_b[i] || rs !== 1'b0) begin
        n_fail++;
        $display("FAIL %s init_byte[%0d]: got rs=%0b data=%02h, required rs=0 data=%02h",
                 tag, i, rs, d, exp_b[i]);
      end
    end
    // Last pulse: HOLD 2 + EXEC 10 low cycles, ready on the 13th.
    c = 1;
    for (int k = 0; k < 100; k++) begin
      tick();
      c++;
      if (cmd_ready_o === 1'b1) break;
    end
    n_checks++;
    if (c !== 13) begin
      n_fail++;
      $display("FAIL %s init_ready_time: got %0d, required 13", tag, c);
    end
    n_checks++;
    if (status_o !== 32'h2 || cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s init_status: got status=%08h ready=%0b, required 00000002/1", tag, status_o, cmd_ready_o);
    end
    $display("%s: init sequence observed, status=%08h", tag, status_o);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o, cmd_ready_o} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: on=%0b en=%0b rs=%0b rw=%0b data=%02h ready=%0b, required all 0",
               lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o, cmd_ready_o);
    end
    rst_i = 1'b0;
    tick();
    n_checks++;
    if (lcd_on_o !== 1'b1 || cmd_ready_o !== 1'b0 || status_o !== 32'h1) begin
      n_fail++;
      $display("FAIL reset_release: on=%0b ready=%0b status=%08h, required 1/0/00000001",
               lcd_on_o, cmd_ready_o, status_o);
    end
    $display("reset: released, status=%08h", status_o);
  endtask

  // 'A' data write: EN rises in cycle 3 after accept, ready again in cycle 19.
  task automatic test_data_write();
    int n;
    n_checks++;
    if (cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL data_pre_ready: got %0b, required 1", cmd_ready_o);
    end
    send_cmd(32'h8000_0241);
    n = 1;
    n_checks++;
    if (cmd_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL data_ready_drop: got %0b, required 0", cmd_ready_o);
    end
    while (lcd_en_o !== 1'b1 && n < 50) begin tick(); n++; end
    n_checks++;
    if (n !== 3) begin
      n_fail++;
      $display("FAIL data_en_latency: got %0d, required 3", n);
    end
    n_checks++;
    if (lcd_rs_o !== 1'b1 || lcd_data_o !== 8'h41 || lcd_rw_o !== 1'b0 || lcd_on_o !== 1'b1) begin
      n_fail++;
      $display("FAIL data_bus: rs=%0b data=%02h rw=%0b on=%0b, required 1/41/0/1",
               lcd_rs_o, lcd_data_o, lcd_rw_o, lcd_on_o);
    end
    while (cmd_ready_o !== 1'b1 && n < 100) begin tick(); n++; end
    n_checks++;
    if (n !== 19) begin
      n_fail++;
      $display("FAIL data_ready_time: got %0d, required 19", n);
    end
    $display("data write 0x41: EN at cycle 3, ready at cycle %0d", n);
  endtask

  // Clear command: 2+4+2+30 cycles of busy, ready in cycle 39.
  task automatic test_clear_cmd();
    int n, busy_bad;
    send_cmd(32'h8000_0001);
    n = 1;
    busy_bad = 0;
    while (cmd_ready_o !== 1'b1 && n < 200) begin
      if (status_o[0] !== 1'b1) busy_bad++;
      tick();
      n++;
    end
    n_checks++;
    if (n !== 39) begin
      n_fail++;
      $display("FAIL clear_ready_time: got %0d, required 39", n);
    end
    n_checks++;
    if (busy_bad !== 0) begin
      n_fail++;
      $display("FAIL clear_busy: %0d samples not busy, required 0", busy_bad);
    end
    n_checks++;
    if (lcd_data_o !== 8'h01 || lcd_rs_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_bus: rs=%0b data=%02h, required 0/01", lcd_rs_o, lcd_data_o);
    end
    $display("clear cmd: ready at cycle %0d", n);
  endtask

  // Valid pulses during a transfer must not start another pulse or touch the bus.
  task automatic test_ignore_busy();
    int n, rises, bad;
    logic prev_en;
    send_cmd(32'h8000_0248);
    n = 1;
    rises = 0;
    bad = 0;
    prev_en = 1'b0;
    while (cmd_ready_o !== 1'b1 && n < 100) begin
      if (lcd_en_o === 1'b1 && prev_en !== 1'b1) rises++;
      if (lcd_data_o !== 8'h48) bad++;
      prev_en = lcd_en_o;
      cmd_valid_i = (n == 5) || (n == 12);
      cmd_data_i  = 32'h8000_0242;
      tick();
      n++;
    end
    cmd_valid_i = 1'b0;
    repeat (3) begin
      if (lcd_en_o === 1'b1) rises++;
      if (lcd_data_o !== 8'h48) bad++;
      tick();
    end
    n_checks++;
    if (rises !== 1) begin
      n_fail++;
      $display("FAIL ignore_pulses: got %0d EN pulses, required 1", rises);
    end
    n_checks++;
    if (bad !== 0 || n !== 19) begin
      n_fail++;
      $display("FAIL ignore_bus: %0d bad data samples, ready at %0d, required 0 and 19", bad, n);
    end
    $display("ignored mid-transfer valid: %0d EN pulse(s)", rises);
  endtask

  // Back-to-back accepts; LCD_ON bit follows the command on the accept edge.
  task automatic test_back_to_back();
    int n;
    send_cmd(32'h0000_0230);
    n_checks++;
    if (lcd_on_o !== 1'b0 || lcd_data_o !== 8'h30) begin
      n_fail++;
      $display("FAIL b2b_on_off: on=%0b data=%02h, required 0/30", lcd_on_o, lcd_data_o);
    end
    n = 1;
    while (cmd_ready_o !== 1'b1 && n < 100) begin tick(); n++; end
    send_cmd(32'h8000_0231);
    n_checks++;
    if (lcd_on_o !== 1'b1 || lcd_data_o !== 8'h31 || cmd_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_on_on: on=%0b data=%02h ready=%0b, required 1/31/0", lcd_on_o, lcd_data_o, cmd_ready_o);
    end
    n = 1;
    while (cmd_ready_o !== 1'b1 && n < 100) begin tick(); n++; end
    n_checks++;
    if (n !== 19) begin
      n_fail++;
      $display("FAIL b2b_ready_time: got %0d, required 19", n);
    end
    $display("back-to-back: second command done at cycle %0d", n);
  endtask

  // Reset during EN high: EN drops on the reset edge, init replays after release.
  task automatic test_reset_mid();
    int lows;
    bit ok;
    send_cmd(32'h8000_0245);
    wait_en_rise(50, lows, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstmid_en_rise: EN high=%0b, required 1", ok);
    end
    rst_i = 1'b1;
    tick();
    n_checks++;
    if (lcd_en_o !== 1'b0 || lcd_on_o !== 1'b0 || cmd_ready_o !== 1'b0 ||
        lcd_data_o !== 8'h00 || status_o !== 32'h1) begin
      n_fail++;
      $display("FAIL rstmid_abort: en=%0b on=%0b ready=%0b data=%02h status=%08h, required 0/0/0/00/00000001",
               lcd_en_o, lcd_on_o, cmd_ready_o, lcd_data_o, status_o);
    end
    tick();
    rst_i = 1'b0;
    tick();
    n_checks++;
    if (lcd_on_o !== 1'b1 || status_o !== 32'h1) begin
      n_fail++;
      $display("FAIL rstmid_release: on=%0b status=%08h, required 1/00000001", lcd_on_o, status_o);
    end
    run_init_check("replay");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    run_init_check("powerup");
    test_data_write();
    test_clear_cmd();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
